sram_resp: RTL and testbench



---
 rtl/sram_pkg.sv | 23 ++
 rtl/sram_resp_if.sv | 16 +
 rtl/sram_resp_mem.sv | 39 +++
 rtl/sram_resp.sv | 188 ++++++++++++++++++
 tb/tb_sram_resp.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_pkg.sv
// Shared types and constants for the SRAM pin-level responder.
// SRAM_RESP_PRELOAD_EN selects the memory preload image built from PRELOAD_PATTERN.
package sram_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RD_WAIT   = 2'd1,
    RD_DRIVE  = 2'd2,
    WR_ACTIVE = 2'd3
  } state_e;

  localparam int unsigned LANE_HI    = 1;
  localparam int unsigned LANE_LO    = 0;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned CNT_WIDTH  = 16;

  localparam logic [15:0] PRELOAD_PATTERN = 16'hA5A5;

  function automatic logic [15:0] preload_word(input int unsigned i);
    return 16'(i) ^ PRELOAD_PATTERN;
  endfunction

endpackage

// File: rtl/sram_resp_if.sv
// Control pins of the asynchronous-SRAM bus; the shared data bus is a separate tri-state port.
interface sram_resp_if #(
  parameter int unsigned ADDR_WIDTH = 19
);

  logic [ADDR_WIDTH-1:0] addr;
  logic                  ce_n;
  logic                  oe_n;
  logic                  we_n;
  logic                  ub_n;
  logic                  lb_n;

  modport master (output addr, ce_n, oe_n, we_n, ub_n, lb_n);
  modport slave  (input  addr, ce_n, oe_n, we_n, ub_n, lb_n);

endinterface

// File: rtl/sram_resp_mem.sv
// Single-port RAM with byte-lane write enables and a registered read port.
// Optional build macro SRAM_RESP_PRELOAD_EN gives the array a preload image.
module sram_resp_mem
  import sram_pkg::*;
#(
  parameter int unsigned DEPTH = 4096,
  parameter int unsigned WIDTH = 16,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] idx,
  input  logic [1:0]       wr_be,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rdata
);

`ifdef SRAM_RESP_PRELOAD_EN
  typedef logic [WIDTH-1:0] mem_t [DEPTH];

  function automatic mem_t preload_image();
    mem_t img;
    for (int unsigned i = 0; i < DEPTH; i++) img[i] = preload_word(i);
    return img;
  endfunction

  mem_t mem = preload_image();
`else
  logic [WIDTH-1:0] mem [DEPTH];
`endif

  // No reset on the array or read register so the tools infer block RAM.
  always_ff @(posedge clk) begin
    if (wr_be[LANE_HI]) mem[idx][WIDTH-1:BYTE_W] <= wdata[WIDTH-1:BYTE_W];
    if (wr_be[LANE_LO]) mem[idx][BYTE_W-1:0]     <= wdata[BYTE_W-1:0];
    if (rd_en)          rdata                    <= mem[idx];
  end

endmodule

// File: rtl/sram_resp.sv
// Device-side responder for the asynchronous-SRAM pin bus: stores writes, returns reads after READ_LAT.
// Build macro SRAM_RESP_PRELOAD_EN preloads the memory (see sram_resp_mem).
module sram_resp
  import sram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 19,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned MEM_DEPTH  = 4096,
  parameter int unsigned READ_LAT   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sram_resp_if.slave           pins,
  inout  wire [DATA_WIDTH-1:0] sram_data,
  output logic [CNT_WIDTH-1:0] wr_count,
  output logic [CNT_WIDTH-1:0] rd_count,
  output logic                 busy,
  output logic                 err_conflict
);

  localparam int unsigned IDX_W = $clog2(MEM_DEPTH);
  localparam int unsigned LAT_W = 3;
  localparam logic [LAT_W-1:0] LAT_RELOAD = LAT_W'(READ_LAT - 1);

  logic [ADDR_WIDTH-1:0] s_addr;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_ce_n, s_oe_n, s_we_n, s_ub_n, s_lb_n, we_n_d;

  // Single register stage on every pin; all decisions below use these.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_addr <= '0;
      s_data <= '0;
      s_ce_n <= 1'b1;
      s_oe_n <= 1'b1;
      s_we_n <= 1'b1;
      s_ub_n <= 1'b1;
      s_lb_n <= 1'b1;
      we_n_d <= 1'b1;
    end else begin
      s_addr <= pins.addr;
      s_data <= sram_data;
      s_ce_n <= pins.ce_n;
      s_oe_n <= pins.oe_n;
      s_we_n <= pins.we_n;
      s_ub_n <= pins.ub_n;
      s_lb_n <= pins.lb_n;
      we_n_d <= s_we_n;
    end
  end

  state_e                state, state_n;
  logic [ADDR_WIDTH-1:0] addr_r, addr_n;
  logic [DATA_WIDTH-1:0] wdata_r, wdata_n;
  logic [1:0]            be_r, be_n;
  logic [LAT_W-1:0]      cnt_r, cnt_n;
  logic                  drive_en_r, drive_n;
  logic                  wr_inc, rd_inc, mem_rd;
  logic [1:0]            mem_be;
  logic [DATA_WIDTH-1:0] rdata;

  logic wr_req, rd_req, conflict, we_rise;
  assign wr_req   = ~s_ce_n & ~s_we_n;
  assign rd_req   = ~s_ce_n & ~s_oe_n;
  assign conflict = wr_req & ~s_oe_n;
  assign we_rise  = s_we_n & ~we_n_d;

  // Write path wins over read whenever we_n is low, including mid-read.
  always_comb begin
    state_n = state;
    addr_n  = addr_r;
    wdata_n = wdata_r;
    be_n    = be_r;
    cnt_n   = cnt_r;
    drive_n = 1'b0;
    wr_inc  = 1'b0;
    rd_inc  = 1'b0;
    mem_rd  = 1'b0;
    mem_be  = 2'b00;
    unique case (state)
      IDLE: begin
        if (wr_req) begin
          state_n = WR_ACTIVE;
          addr_n  = s_addr;
          wdata_n = s_data;
          be_n    = {~s_ub_n, ~s_lb_n};
        end else if (rd_req) begin
          state_n = RD_WAIT;
          addr_n  = s_addr;
          cnt_n   = LAT_RELOAD;
        end
      end
      WR_ACTIVE: begin
        if (we_rise) begin
          mem_be  = be_r;
          wr_inc  = 1'b1;
          state_n = IDLE;
        end else if (s_ce_n) begin
          state_n = IDLE;
        end else if (!s_we_n) begin
          addr_n  = s_addr;
          wdata_n = s_data;
          be_n    = {~s_ub_n, ~s_lb_n};
        end
      end
      RD_WAIT: begin
        if (wr_req) begin
          state_n = WR_ACTIVE;
          addr_n  = s_addr;
          wdata_n = s_data;
          be_n    = {~s_ub_n, ~s_lb_n};
        end else if (s_ce_n || s_oe_n) begin
          state_n = IDLE;
        end else if (cnt_r == '0) begin
          state_n = RD_DRIVE;
          mem_rd  = 1'b1;
          drive_n = 1'b1;
        end else begin
          cnt_n = cnt_r - LAT_W'(1);
        end
      end
      RD_DRIVE: begin
        if (wr_req) begin
          state_n = WR_ACTIVE;
          addr_n  = s_addr;
          wdata_n = s_data;
          be_n    = {~s_ub_n, ~s_lb_n};
        end else if (s_ce_n || s_oe_n) begin
          rd_inc  = 1'b1;
          state_n = IDLE;
        end else if (s_addr != addr_r) begin
          state_n = RD_WAIT;
          addr_n  = s_addr;
          cnt_n   = LAT_RELOAD;
        end else begin
          drive_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      addr_r       <= '0;
      wdata_r      <= '0;
      be_r         <= 2'b00;
      cnt_r        <= '0;
      drive_en_r   <= 1'b0;
      wr_count     <= '0;
      rd_count     <= '0;
      err_conflict <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_n;
      addr_r       <= addr_n;
      wdata_r      <= wdata_n;
      be_r         <= be_n;
      cnt_r        <= cnt_n;
      drive_en_r   <= drive_n;
      busy         <= (state_n != IDLE);
      err_conflict <= err_conflict | conflict;
      if (wr_inc && (wr_count != '1)) wr_count <= wr_count + CNT_WIDTH'(1);
      if (rd_inc && (rd_count != '1)) rd_count <= rd_count + CNT_WIDTH'(1);
    end
  end

  sram_resp_mem #(
    .DEPTH (MEM_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_mem (
    .clk   (clk),
    .idx   (addr_r[IDX_W-1:0]),
    .wr_be (mem_be),
    .wdata (wdata_r),
    .rd_en (mem_rd),
    .rdata (rdata)
  );

  // Raw pins gate the drive so the bus is released the moment oe_n/ce_n rise or we_n falls.
  logic drive;
  assign drive = drive_en_r & ~pins.oe_n & ~pins.ce_n & pins.we_n;

  assign sram_data[DATA_WIDTH-1:BYTE_W] = (drive && !pins.ub_n) ? rdata[DATA_WIDTH-1:BYTE_W] : 8'hzz;
  assign sram_data[BYTE_W-1:0]          = (drive && !pins.lb_n) ? rdata[BYTE_W-1:0]          : 8'hzz;

endmodule

// File: tb/tb_sram_resp.sv
// Bench for sram_resp: two instances (READ_LAT 1 and 3) share one pin interface; data nets pull low when undriven.
module tb_sram_resp;

  localparam int unsigned AW    = 19;
  localparam int          LAT1  = 3;   // negedges from pin change to first driven sample, READ_LAT=1
  localparam int          LAT3  = 5;   // same for READ_LAT=3

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sram_resp_if #(.ADDR_WIDTH(AW)) pins ();

  tri0 [15:0] data1;
  tri0 [15:0] data3;
  logic        tb_drv = 1'b0;
  logic [15:0] tb_wdata = 16'h0;
  assign data1 = tb_drv ? tb_wdata : 16'hzzzz;
  assign data3 = tb_drv ? tb_wdata : 16'hzzzz;

  logic [15:0] wr1, rd1, wr3, rd3;
  logic        busy1, busy3, err1, err3;

  sram_resp #(.READ_LAT(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .pins(pins), .sram_data(data1),
    .wr_count(wr1), .rd_count(rd1), .busy(busy1), .err_conflict(err1)
  );

  sram_resp #(.READ_LAT(3)) u_lat3 (
    .clk(clk), .rst_n(rst_n), .pins(pins), .sram_data(data3),
    .wr_count(wr3), .rd_count(rd3), .busy(busy3), .err_conflict(err3)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] q1[$];
  logic [15:0] q3[$];

  typedef struct {
    bit          is_wr;
    logic [18:0] addr;
    logic [15:0] data;
    bit          ub_n;
    bit          lb_n;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_counts(input string tag, input int w, input int r);
    check({tag, " wr_count lat1"}, 32'(wr1), 32'(w));
    check({tag, " wr_count lat3"}, 32'(wr3), 32'(w));
    check({tag, " rd_count lat1"}, 32'(rd1), 32'(r));
    check({tag, " rd_count lat3"}, 32'(rd3), 32'(r));
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pins_idle();
    pins.ce_n = 1'b1; pins.oe_n = 1'b1; pins.we_n = 1'b1;
    pins.ub_n = 1'b1; pins.lb_n = 1'b1; tb_drv = 1'b0;
  endtask

  task automatic do_write(input logic [18:0] a, input logic [15:0] d, input bit ub, input bit lb);
    @(negedge clk);
    pins.addr = a; tb_wdata = d; tb_drv = 1'b1;
    pins.ce_n = 1'b0; pins.oe_n = 1'b1; pins.we_n = 1'b0;
    pins.ub_n = ub; pins.lb_n = lb;
    idle(2);
    @(negedge clk);
    pins.we_n = 1'b1;
    @(negedge clk);
    pins_idle();
    idle(2);
  endtask

  // Wait for each instance to start driving; pop its expected word and check data and latency.
  task automatic collect(input int start);
    int n = start;
    bit seen1 = 1'b0;
    bit seen3 = 1'b0;
    logic [15:0] e;
    while (!(seen1 && seen3) && n < start + 16) begin
      @(negedge clk);
      n++;
      if (!seen1 && data1 !== 16'h0) begin
        seen1 = 1'b1;
        e = q1.pop_front();
        check("rd_data lat1", 32'(data1), 32'(e));
        check("rd_latency lat1", 32'(n), 32'(LAT1));
      end
      if (!seen3 && data3 !== 16'h0) begin
        seen3 = 1'b1;
        e = q3.pop_front();
        check("rd_data lat3", 32'(data3), 32'(e));
        check("rd_latency lat3", 32'(n), 32'(LAT3));
      end
    end
    if (!seen1) begin
      vectors++; miscompares++;
      $display("FAIL rd_timeout lat1: no drive after %0d cycles, required data %h", n, q1.size() > 0 ? q1[0] : 16'h0);
      if (q1.size() > 0) void'(q1.pop_front());
    end
    if (!seen3) begin
      vectors++; miscompares++;
      $display("FAIL rd_timeout lat3: no drive after %0d cycles, required data %h", n, q3.size() > 0 ? q3[0] : 16'h0);
      if (q3.size() > 0) void'(q3.pop_front());
    end
  endtask

  task automatic rd_start(input logic [18:0] a, input bit ub, input bit lb, input logic [15:0] e);
    @(negedge clk);
    pins.addr = a; tb_drv = 1'b0;
    pins.ce_n = 1'b0; pins.oe_n = 1'b0; pins.we_n = 1'b1;
    pins.ub_n = ub; pins.lb_n = lb;
    q1.push_back(e);
    q3.push_back(e);
    collect(0);
  endtask

  task automatic rd_end();
    @(negedge clk);
    pins.oe_n = 1'b1;
    #1;
    check("oe_release lat1", 32'(data1), 32'h0);
    check("oe_release lat3", 32'(data3), 32'h0);
    @(negedge clk);
    pins_idle();
    idle(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b1, 19'h00010, 16'hBEEF, 1'b0, 1'b0, 16'h0000};
    vecs[1]  = '{1'b0, 19'h00010, 16'h0000, 1'b0, 1'b0, 16'hBEEF};
    vecs[2]  = '{1'b1, 19'h00020, 16'h1234, 1'b0, 1'b0, 16'h0000};
    vecs[3]  = '{1'b1, 19'h00020, 16'hFF00, 1'b0, 1'b1, 16'h0000};
    vecs[4]  = '{1'b0, 19'h00020, 16'h0000, 1'b0, 1'b0, 16'hFF34};
    vecs[5]  = '{1'b0, 19'h00020, 16'h0000, 1'b1, 1'b0, 16'h0034};
    vecs[6]  = '{1'b1, 19'h01005, 16'h5555, 1'b0, 1'b0, 16'h0000};
    vecs[7]  = '{1'b0, 19'h00005, 16'h0000, 1'b0, 1'b0, 16'h5555};
    vecs[8]  = '{1'b1, 19'h00030, 16'h6789, 1'b0, 1'b0, 16'h0000};
    vecs[9]  = '{1'b1, 19'h00030, 16'hABCD, 1'b1, 1'b1, 16'h0000};
    vecs[10] = '{1'b0, 19'h00030, 16'h0000, 1'b0, 1'b0, 16'h6789};
    vecs[11] = '{1'b1, 19'h7FFFF, 16'hC3C3, 1'b0, 1'b0, 16'h0000};
    vecs[12] = '{1'b0, 19'h00FFF, 16'h0000, 1'b0, 1'b0, 16'hC3C3};

    pins.addr = '0;
    pins_idle();
    rst_n = 1'b0;
    idle(3);
    check_counts("reset", 0, 0);
    check("reset err lat1", 32'(err1), 32'h0);
    check("reset err lat3", 32'(err3), 32'h0);
    check("reset busy lat1", 32'(busy1), 32'h0);
    check("reset bus lat1", 32'(data1), 32'h0);
    check("reset bus lat3", 32'(data3), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Table: writes, byte lanes, address wrap, both-lanes-disabled write.
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].is_wr) begin
        do_write(vecs[i].addr, vecs[i].data, vecs[i].ub_n, vecs[i].lb_n);
      end else begin
        rd_start(vecs[i].addr, vecs[i].ub_n, vecs[i].lb_n, vecs[i].exp);
        rd_end();
      end
    end
    check_counts("table", 7, 6);
    check("table err lat1", 32'(err1), 32'h0);
    check("table busy lat3", 32'(busy3), 32'h0);

    // Address change while driving restarts the latency wait.
    rd_start(19'h00010, 1'b0, 1'b0, 16'hBEEF);
    @(negedge clk);
    pins.addr = 19'h00020;
    q1.push_back(16'hFF34);
    q3.push_back(16'hFF34);
    idle(2);
    check("addr_chg release lat1", 32'(data1), 32'h0);
    check("addr_chg release lat3", 32'(data3), 32'h0);
    collect(2);
    rd_end();
    check_counts("addr_chg", 7, 7);

    // Conflict during a driven read: write wins, bus released, flag sticky.
    rd_start(19'h00010, 1'b0, 1'b0, 16'hBEEF);
    @(negedge clk);
    pins.we_n = 1'b0;
    #1;
    check("conflict hiz lat1", 32'(data1), 32'h0);
    check("conflict hiz lat3", 32'(data3), 32'h0);
    idle(3);
    check("conflict err lat1", 32'(err1), 32'h1);
    check("conflict err lat3", 32'(err3), 32'h1);
    check("conflict busy lat1", 32'(busy1), 32'h1);
    check("conflict busy lat3", 32'(busy3), 32'h1);
    @(negedge clk);
    pins.addr = 19'h00050; tb_wdata = 16'h0F0F; tb_drv = 1'b1;
    idle(2);
    @(negedge clk);
    pins.we_n = 1'b1; pins.oe_n = 1'b1;
    @(negedge clk);
    pins_idle();
    idle(3);
    check_counts("conflict", 8, 7);
    check("conflict busy_after lat1", 32'(busy1), 32'h0);
    rd_start(19'h00050, 1'b0, 1'b0, 16'h0F0F);
    rd_end();
    rd_start(19'h00010, 1'b0, 1'b0, 16'hBEEF);
    rd_end();

    // ce_n rising before we_n aborts the write.
    @(negedge clk);
    pins.addr = 19'h00010; tb_wdata = 16'h9999; tb_drv = 1'b1;
    pins.ce_n = 1'b0; pins.we_n = 1'b0; pins.ub_n = 1'b0; pins.lb_n = 1'b0;
    idle(2);
    @(negedge clk);
    pins.ce_n = 1'b1;
    @(negedge clk);
    pins_idle();
    idle(2);
    rd_start(19'h00010, 1'b0, 1'b0, 16'hBEEF);
    rd_end();
    check_counts("abort", 8, 10);
    check("abort err sticky lat1", 32'(err1), 32'h1);
    check("abort err sticky lat3", 32'(err3), 32'h1);

    // Reset during a write discards it; memory keeps the prior value.
    do_write(19'h00060, 16'h1111, 1'b0, 1'b0);
    @(negedge clk);
    pins.addr = 19'h00060; tb_wdata = 16'h2222; tb_drv = 1'b1;
    pins.ce_n = 1'b0; pins.we_n = 1'b0; pins.ub_n = 1'b0; pins.lb_n = 1'b0;
    idle(2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_counts("rst_wr", 0, 0);
    check("rst_wr err lat1", 32'(err1), 32'h0);
    check("rst_wr busy lat3", 32'(busy3), 32'h0);
    @(negedge clk);
    pins_idle();
    idle(2);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Reset during a driven read releases the bus at once.
    rd_start(19'h00060, 1'b0, 1'b0, 16'h1111);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_rd release lat1", 32'(data1), 32'h0);
    check("rst_rd release lat3", 32'(data3), 32'h0);
    @(negedge clk);
    pins_idle();
    idle(1);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    check_counts("rst_rd", 0, 0);
    rd_start(19'h00060, 1'b0, 1'b0, 16'h1111);
    rd_end();
    check_counts("final", 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
